// File: rtl/reg_write_arbiter_if.sv
// Register-file write-port arbitration bus: WB and AUX requests, the AUX
// reservation strobe, the busy scoreboard and the shared write port.
interface reg_write_arbiter_if #(
    parameter int unsigned NUM_REGS = 11
) ();
    logic                wbValid;
    logic [3:0]          wbIndex;
    logic [15:0]         wbData;
    logic                auxValid;
    logic [3:0]          auxIndex;
    logic [15:0]         auxData;
    logic                auxReady;
    logic                reserveValid;
    logic [3:0]          reserveIndex;
    logic [NUM_REGS-1:0] busy;
    logic                wbStall;
    logic                rfWriteEnable;
    logic [3:0]          rfWriteIndex;
    logic [15:0]         rfDataToWrite;

    // Requesters / register file side
    modport master (
        output wbValid, wbIndex, wbData,
        output auxValid, auxIndex, auxData,
        output reserveValid, reserveIndex,
        input  auxReady, busy, wbStall,
        input  rfWriteEnable, rfWriteIndex, rfDataToWrite
    );

    // Arbiter side
    modport slave (
        input  wbValid, wbIndex, wbData,
        input  auxValid, auxIndex, auxData,
        input  reserveValid, reserveIndex,
        output auxReady, busy, wbStall,
        output rfWriteEnable, rfWriteIndex, rfDataToWrite
    );
endinterface

// File: rtl/reg_write_arbiter.sv
// Shares the register file's single write port between the write-back stage
// (normally preferred) and a multi-cycle AUX unit. After STARVE_LIMIT
// consecutive AUX losses, one cycle is forced to AUX by stalling WB. A busy
// scoreboard marks registers with outstanding AUX writes for decode interlock.
module reg_write_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned NUM_REGS     = 11
) (
    input logic                 clk,
    input logic                 rst,
    reg_write_arbiter_if.slave  io_arb
);

    typedef enum logic {
        ST_ARB   = 1'b0,
        ST_FORCE = 1'b1
    } state_t;

    localparam logic [2:0] LP_LOSS_MAX = 3'(STARVE_LIMIT - 1);
    localparam logic [4:0] LP_NUM_REGS = 5'(NUM_REGS);

    state_t              r_state;
    logic [2:0]          r_lossCount;
    logic                r_wbStall;
    logic [NUM_REGS-1:0] r_busy;

    logic                w_auxReady;
    logic                w_grantWb;
    logic                w_grantAux;
    logic                w_loss;
    logic                w_wbInRange;
    logic                w_auxInRange;
    logic                w_resInRange;
    logic                w_auxXfer;
    logic                w_rfWe;
    logic [3:0]          w_rfIdx;
    logic [15:0]         w_rfData;
    logic [NUM_REGS-1:0] w_busyNext;

    assign w_wbInRange  = ({1'b0, io_arb.wbIndex}      < LP_NUM_REGS);
    assign w_auxInRange = ({1'b0, io_arb.auxIndex}     < LP_NUM_REGS);
    assign w_resInRange = ({1'b0, io_arb.reserveIndex} < LP_NUM_REGS);

    // A loss only counts in ARB; FORCE grants AUX unconditionally.
    assign w_loss    = (r_state == ST_ARB) && io_arb.auxValid && io_arb.wbValid;
    assign w_auxXfer = io_arb.auxValid && w_auxReady;

    // Grant decision; everything is held off while reset is asserted.
    always_comb begin
        w_auxReady = 1'b0;
        w_grantWb  = 1'b0;
        w_grantAux = 1'b0;
        if (rst) begin
            if (r_state == ST_FORCE) begin
                w_auxReady = 1'b1;
                w_grantAux = io_arb.auxValid;
            end else begin
                w_auxReady = !io_arb.wbValid;
                w_grantWb  = io_arb.wbValid;
                w_grantAux = !io_arb.wbValid && io_arb.auxValid;
            end
        end
    end

    // Drive the write port from the grant; out-of-range indices are granted
    // (handshake completes) but never reach the register file.
    always_comb begin
        w_rfWe   = 1'b1;
        w_rfIdx  = '0;
        w_rfData = '0;
        if (w_grantWb && w_wbInRange) begin
            w_rfWe   = 1'b0;
            w_rfIdx  = io_arb.wbIndex;
            w_rfData = io_arb.wbData;
        end else if (w_grantAux && w_auxInRange) begin
            w_rfWe   = 1'b0;
            w_rfIdx  = io_arb.auxIndex;
            w_rfData = io_arb.auxData;
        end
    end

    // Starvation FSM: count consecutive AUX losses, force one AUX cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= ST_ARB;
            r_lossCount <= '0;
            r_wbStall   <= 1'b0;
        end else begin
            case (r_state)
                ST_ARB: begin
                    if (w_loss) begin
                        if (r_lossCount == LP_LOSS_MAX) begin
                            r_state     <= ST_FORCE;
                            r_lossCount <= '0;
                            r_wbStall   <= 1'b1;
                        end else begin
                            r_lossCount <= r_lossCount + 3'd1;
                        end
                    end else begin
                        r_lossCount <= '0;
                    end
                end
                ST_FORCE: begin
                    r_state     <= ST_ARB;
                    r_lossCount <= '0;
                    r_wbStall   <= 1'b0;
                end
                default: begin
                    r_state     <= ST_ARB;
                    r_lossCount <= '0;
                    r_wbStall   <= 1'b0;
                end
            endcase
        end
    end

    // Next busy vector: clear on AUX transfer, then set on reserve so a
    // same-cycle set and clear of one register leaves it busy.
    always_comb begin
        w_busyNext = r_busy;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (w_auxXfer && w_auxInRange && (io_arb.auxIndex == 4'(i))) begin
                w_busyNext[i] = 1'b0;
            end
            if (io_arb.reserveValid && w_resInRange && (io_arb.reserveIndex == 4'(i))) begin
                w_busyNext[i] = 1'b1;
            end
        end
    end

    // Busy scoreboard register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busyNext;
        end
    end

    assign io_arb.auxReady      = w_auxReady;
    assign io_arb.wbStall       = r_wbStall && rst;
    assign io_arb.busy          = r_busy;
    assign io_arb.rfWriteEnable = w_rfWe;
    assign io_arb.rfWriteIndex  = w_rfIdx;
    assign io_arb.rfDataToWrite = w_rfData;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Scoreboard bench for reg_write_arbiter: directed scenarios followed by
// randomized traffic, each cycle's expected outputs queued by the driver and
// checked at the negedge by an independent monitor.
module tb_reg_write_arbiter;

    localparam int unsigned STARVE_LIMIT = 4;
    localparam int unsigned NUM_REGS     = 11;

    typedef struct {
        logic                auxReady;
        logic                wbStall;
        logic                we;
        logic [3:0]          idx;
        logic [15:0]         data;
        bit                  chkPort;
        logic [NUM_REGS-1:0] busy;
        int                  cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    reg_write_arbiter_if #(.NUM_REGS(NUM_REGS)) u_if ();

    reg_write_arbiter #(
        .STARVE_LIMIT(STARVE_LIMIT),
        .NUM_REGS    (NUM_REGS)
    ) u_dut (
        .clk   (clk),
        .rst   (rst),
        .io_arb(u_if)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    // Reference model state
    int                  m_losses = 0;
    bit                  m_force  = 1'b0;
    logic [NUM_REGS-1:0] m_busy   = '0;
    bit                  lastReady = 1'b0;
    bit                  lastStall = 1'b0;

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", nm, c, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, predict outputs from the rules, queue.
    task automatic step(input bit rn,
                        input bit wv, input logic [3:0] wi, input logic [15:0] wd,
                        input bit av, input logic [3:0] ai, input logic [15:0] ad,
                        input bit rv, input logic [3:0] ri);
        exp_t e;
        bit gw, ga;
        logic [NUM_REGS-1:0] nb;
        rst              = rn;
        u_if.wbValid      = wv;
        u_if.wbIndex      = wi;
        u_if.wbData       = wd;
        u_if.auxValid     = av;
        u_if.auxIndex     = ai;
        u_if.auxData      = ad;
        u_if.reserveValid = rv;
        u_if.reserveIndex = ri;

        e.busy = m_busy;
        e.cyc  = cyc;
        e.idx  = '0;
        e.data = '0;
        e.we   = 1'b1;
        e.chkPort = 1'b1;
        gw = 1'b0;
        ga = 1'b0;
        if (!rn) begin
            e.auxReady = 1'b0;
            e.wbStall  = 1'b0;
            m_losses   = 0;
            m_force    = 1'b0;
            m_busy     = '0;
        end else begin
            if (m_force) begin
                e.wbStall  = 1'b1;
                e.auxReady = 1'b1;
                ga         = av;
                m_force    = 1'b0;
                m_losses   = 0;
            end else begin
                e.wbStall  = 1'b0;
                e.auxReady = !wv;
                gw         = wv;
                ga         = !wv && av;
                if (wv && av) begin
                    m_losses++;
                    if (m_losses >= int'(STARVE_LIMIT)) begin
                        m_force  = 1'b1;
                        m_losses = 0;
                    end
                end else begin
                    m_losses = 0;
                end
            end
            if (gw) begin
                if (int'(wi) < int'(NUM_REGS)) begin
                    e.we = 1'b0; e.idx = wi; e.data = wd;
                end else begin
                    e.chkPort = 1'b0;
                end
            end else if (ga) begin
                if (int'(ai) < int'(NUM_REGS)) begin
                    e.we = 1'b0; e.idx = ai; e.data = ad;
                end else begin
                    e.chkPort = 1'b0;
                end
            end
            nb = m_busy;
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                if (ga && int'(ai) == i) nb[i] = 1'b0;
                if (rv && int'(ri) == i) nb[i] = 1'b1;
            end
            m_busy = nb;
        end
        q.push_back(e);
        lastReady = e.auxReady;
        lastStall = e.wbStall;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle();
        step(1, 0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 0, 4'd0);
    endtask

    // Monitor: compare every presented output against the queued prediction.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("auxReady",      e.cyc, 32'(u_if.auxReady),      32'(e.auxReady));
            chk("wbStall",       e.cyc, 32'(u_if.wbStall),       32'(e.wbStall));
            chk("rfWriteEnable", e.cyc, 32'(u_if.rfWriteEnable), 32'(e.we));
            if (e.chkPort) begin
                chk("rfWriteIndex",  e.cyc, 32'(u_if.rfWriteIndex),  32'(e.idx));
                chk("rfDataToWrite", e.cyc, 32'(u_if.rfDataToWrite), 32'(e.data));
            end
            chk("busy", e.cyc, 32'(u_if.busy), 32'(e.busy));
        end
    end

    initial begin
        bit          auxPend;
        logic [3:0]  pAi;
        logic [15:0] pAd;
        bit          rwv, rn, rv, av;
        logic [3:0]  rwi, ri;
        logic [15:0] rwd;

        u_if.wbValid = 0; u_if.wbIndex = 0; u_if.wbData = 0;
        u_if.auxValid = 0; u_if.auxIndex = 0; u_if.auxData = 0;
        u_if.reserveValid = 0; u_if.reserveIndex = 0;
        @(posedge clk);
        #1;

        // Reset with every request asserted
        step(0, 1, 4'd3, 16'h1234, 1, 4'd5, 16'hAAAA, 1, 4'd4);
        step(0, 1, 4'd3, 16'h1234, 1, 4'd5, 16'hAAAA, 1, 4'd4);
        idle(); idle();

        // WB only
        step(1, 1, 4'd3, 16'h1234, 0, 4'd0, 16'h0, 0, 4'd0);

        // Collision, then AUX wins once WB drops
        idle();
        step(1, 1, 4'd2, 16'h0001, 1, 4'd5, 16'hAAAA, 0, 4'd0);
        step(1, 0, 4'd0, 16'h0000, 1, 4'd5, 16'hAAAA, 0, 4'd0);
        idle();

        // Starvation: four losses, one forced AUX cycle, WB resumes
        for (int i = 0; i < 5; i++)
            step(1, 1, 4'd1, 16'h5555, 1, 4'd9, 16'hBEEF, 0, 4'd0);
        step(1, 1, 4'd1, 16'h5555, 0, 4'd0, 16'h0, 0, 4'd0);
        idle();

        // Scoreboard set / clear / simultaneous set+clear
        step(1, 0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 1, 4'd7);
        idle(); idle();
        step(1, 0, 4'd0, 16'h0, 1, 4'd7, 16'h7777, 0, 4'd0);
        idle();
        step(1, 0, 4'd0, 16'h0, 1, 4'd7, 16'h7070, 1, 4'd7);
        idle();
        step(1, 0, 4'd0, 16'h0, 1, 4'd7, 16'h0707, 0, 4'd0);
        idle();

        // Out-of-range AUX and WB indices
        step(1, 0, 4'd0, 16'h0, 0, 4'd0, 16'h0, 1, 4'd3);
        step(1, 0, 4'd0, 16'h0, 1, 4'd12, 16'hC0DE, 1, 4'd13);
        step(1, 1, 4'd15, 16'hFFFF, 0, 4'd0, 16'h0, 0, 4'd0);
        idle();

        // Reset during FORCE, then the loss count restarts from zero
        for (int i = 0; i < 4; i++)
            step(1, 1, 4'd0, 16'h1111, 1, 4'd6, 16'h6666, 0, 4'd0);
        step(0, 1, 4'd0, 16'h1111, 1, 4'd6, 16'h6666, 0, 4'd0);
        for (int i = 0; i < 5; i++)
            step(1, 1, 4'd0, 16'h1111, 1, 4'd6, 16'h6666, 0, 4'd0);
        idle();

        // Randomized traffic respecting the AUX hold and WB stall rules
        auxPend = 1'b0;
        pAi = '0; pAd = '0;
        rwv = 1'b0; rwi = '0; rwd = '0;
        for (int n = 0; n < 400; n++) begin
            if (!auxPend && ($urandom_range(0, 99) < 50)) begin
                auxPend = 1'b1;
                pAi = 4'($urandom_range(0, 15));
                pAd = 16'($urandom);
            end
            if (!lastStall) begin
                rwv = ($urandom_range(0, 99) < 65);
                rwi = 4'($urandom_range(0, 15));
                rwd = 16'($urandom);
            end
            rn = ($urandom_range(0, 99) >= 3);
            rv = ($urandom_range(0, 99) < 30);
            ri = 4'($urandom_range(0, 15));
            av = auxPend;
            step(rn, rwv, rwi, rwd, av, pAi, pAd, rv, ri);
            if (av && lastReady) auxPend = 1'b0;
        end
        idle(); idle();

        @(negedge clk);
        #1;
        chk("queue_drained", cyc, 32'(q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Shares the register file's single write port (R0–R7, IH, SP, RA; 4-bit index, 16-bit data, active-low write enable) between two requesters:

- the pipeline write-back stage (WB), which normally has priority;
- a multi-cycle auxiliary unit (AUX, e.g. memory/IO load return), using a valid/ready handshake.

A starvation guard forces one AUX grant after a fixed number of consecutive losses by stalling WB. A busy scoreboard tracks registers with outstanding AUX writes so decode can interlock.

## Interface

Parameters:
- STARVE_LIMIT, 4: consecutive AUX losses before a forced AUX grant; legal range 1–7.
- NUM_REGS, 11: number of architectural registers; indices 0 to NUM_REGS-1 are valid.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- rst  in  1  synchronous, active-low reset.
- wbValid  in  1  WB requests a write this cycle.
- wbIndex  in  4  WB destination index.
- wbData  in  16  WB write data.
- auxValid  in  1  AUX requests a write; held with index/data until auxReady.
- auxIndex  in  4  AUX destination index.
- auxData  in  16  AUX write data.
- auxReady  out  1  AUX granted this cycle; transfer occurs when auxValid && auxReady.
- reserveValid  in  1  AUX launched an operation that will write reserveIndex.
- reserveIndex  in  4  register being reserved.
- busy  out  NUM_REGS  bit i = 1 means register i has an outstanding AUX write.
- wbStall  out  1  WB must hold its request this cycle; not granted.
- rfWriteEnable  out  1  active-low write enable to the register file.
- rfWriteIndex  out  4  write index to the register file.
- rfDataToWrite  out  16  write data to the register file.

## Operation

FSM states and counter:
- FSM has two states, ARB and FORCE.
- lossCount is a 3-bit counter.

ARB state:
- Grant rule: WB if wbValid, else AUX if auxValid.
- auxReady = !wbValid.
- A loss is a cycle with auxValid && wbValid. On a loss, lossCount increments.
- If the loss occurs with lossCount == STARVE_LIMIT-1, the next state is FORCE and lossCount clears.
- lossCount clears on any cycle with auxValid low or with an AUX grant.

FORCE state (always exactly one cycle):
- wbStall = 1 and auxReady = 1.
- AUX is granted regardless of wbValid.
- WB must hold its request, which is not consumed.
- Next state is ARB.
- If auxValid is low in FORCE (a protocol violation), no write occurs and the FSM still returns to ARB.

wbStall:
- wbStall = (state == FORCE). It is a registered decode, never combinational from inputs.

Write port, driven combinationally from the grant:
- rfWriteEnable = 0 only when the granted request has index < NUM_REGS.
- With no grant, rfWriteEnable = 1; index and data are don't-care and are driven 0.

Out-of-range index (>= NUM_REGS):
- WB request: no write.
- AUX request: the handshake still completes (auxReady per rules) but no write occurs and busy is untouched.

Busy scoreboard:
- Set bit on reserveValid with an in-range index.
- Clear bit on AUX transfer to that index.
- Simultaneous set and clear of the same bit: set wins.
- Reserving an already-busy index leaves it at 1; there is no counting.
- WB writes never affect busy.

## Timing

- Reset (rst = 0 at posedge): state ARB, lossCount 0, busy all 0.
- While rst = 0, outputs are forced to: auxReady 0, wbStall 0, rfWriteEnable 1, rfWriteIndex 0, rfDataToWrite 0. No write reaches the register file.
- Reset asserted during FORCE returns the FSM to ARB on the next edge; the pending AUX request stays unacknowledged.
- Write-port latency is 0: the grant and port drive are in the same cycle as the request, and the register file captures the write on that cycle's negedge.
- busy updates (set or clear) become visible the cycle after reserveValid or the AUX transfer.
- Worst-case AUX wait is STARVE_LIMIT cycles from the first loss to the grant.
- WB loses at most 1 cycle per STARVE_LIMIT+1 cycles.

## Test plan

1. Reset: rst = 0 for 2 cycles with wbValid = auxValid = reserveValid = 1 -> rfWriteEnable = 1, auxReady = 0, wbStall = 0, busy = 0; after release, busy stays 0.
2. WB only: wbValid = 1, wbIndex = 3, wbData = 0x1234 -> same cycle rfWriteEnable = 0, rfWriteIndex = 3, rfDataToWrite = 0x1234, auxReady = 0.
3. Collision: cycle 0 both valid (WB idx 2 = 0x0001, AUX idx 5 = 0xAAAA) -> WB written and auxReady = 0. Cycle 1 wbValid = 0 -> AUX idx 5 = 0xAAAA written, auxReady = 1.
4. Starvation, default limit: wbValid held high and AUX idx 9 = 0xBEEF from cycle 0 -> cycles 0–3 write WB. Cycle 4 has wbStall = 1, auxReady = 1 and writes idx 9 = 0xBEEF. Cycle 5 has wbStall = 0 and writes WB.
5. Scoreboard: reserve idx 7 at cycle 0 -> busy[7] = 1 at cycle 1. AUX transfer to idx 7 at cycle 3 -> busy[7] = 0 at cycle 4. A reserve and a transfer to idx 7 in the same cycle -> busy[7] = 1 afterwards.
6. Range and reset: AUX idx 12 -> auxReady = 1, rfWriteEnable = 1, busy unchanged. rst = 0 asserted during FORCE -> wbStall = 0 next cycle and lossCount restarts from 0.
